// File: rtl/instr_fetch.sv
// Instruction fetch stage with IF/ID register and a one-entry skid buffer for hazard stalls.
// Optional IFETCH_PERF_EN adds fetch/bubble performance counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HOLD      = 2'd1,
        HOLD_SKID = 2'd2
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic              inflight_q;
    logic [XLEN-1:0]   inflight_pc_q;
    logic              skid_valid_q;
    logic [XLEN-1:0]   skid_instr_q;
    logic [XLEN-1:0]   skid_pc_q;
    logic              id_valid_q;
    logic [XLEN-1:0]   id_instr_q;
    logic [XLEN-1:0]   id_pc_q;
    logic [XLEN-1:0]   id_pc_plus4_q;

    // Requests are suppressed during reset, stalls and redirects.
    assign imem_req    = rst_n && !stall && !redirect;
    assign imem_addr   = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_opcode   = id_instr_q[6:0];
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;

    // Priority: redirect > stall > advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
        end else if (redirect) begin
            state_q      <= RUN;
            pc_q         <= redirect_pc & ALIGN_MASK;
            inflight_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
        end else if (stall) begin
            inflight_q <= 1'b0;
            if (inflight_q) begin
                // Park the returning word; no new fetch is issued while stalled.
                skid_valid_q <= 1'b1;
                skid_instr_q <= imem_rdata;
                skid_pc_q    <= inflight_pc_q;
                state_q      <= HOLD_SKID;
            end else if (state_q == RUN) begin
                state_q <= HOLD;
            end
        end else begin
            state_q <= RUN;
            if (skid_valid_q) begin
                id_valid_q    <= 1'b1;
                id_instr_q    <= skid_instr_q;
                id_pc_q       <= skid_pc_q;
                id_pc_plus4_q <= skid_pc_q + PC_STEP;
                skid_valid_q  <= 1'b0;
            end else if (inflight_q) begin
                id_valid_q    <= 1'b1;
                id_instr_q    <= imem_rdata;
                id_pc_q       <= inflight_pc_q;
                id_pc_plus4_q <= inflight_pc_q + PC_STEP;
            end else begin
                id_valid_q <= 1'b0;
                id_instr_q <= NOP_INSTR;
            end
            pc_q          <= pc_q + PC_STEP;
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
        end
    end

`ifdef IFETCH_PERF_EN
    logic advance_c;
    logic load_valid_c;

    assign advance_c    = !redirect && !stall;
    assign load_valid_c = skid_valid_q || inflight_q;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (advance_c && load_valid_c) begin
                perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
            end
            if (redirect || (advance_c && !load_valid_c)) begin
                perf_bubble_cnt <= perf_bubble_cnt + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch; two instances (RESET_PC 0 and 0xFFFFFFF8) share stimulus.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC0 = 32'h0000_0000;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req [2];
    logic [31:0] addr [2];
    logic [31:0] rdata [2];
    logic        v [2];
    logic [31:0] ins [2];
    logic [6:0]  opc [2];
    logic [31:0] ipc [2];
    logic [31:0] ipc4 [2];
`ifdef IFETCH_PERF_EN
    logic [31:0] pf [2];
    logic [31:0] pb [2];
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: next fetch address, at most one fetched-but-undelivered PC, ID contents.
    logic [31:0] m_fetch [2];
    bit          m_pend [2];
    logic [31:0] m_pend_pc [2];
    bit          m_valid [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pc [2];
    logic [31:0] m_fcnt [2];
    logic [31:0] m_bcnt [2];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC0), .NOP_INSTR(NOP)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .imem_req(req[0]), .imem_addr(addr[0]), .imem_rdata(rdata[0]),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(v[0]), .id_instr(ins[0]), .id_opcode(opc[0]), .id_pc(ipc[0]), .id_pc_plus4(ipc4[0])
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(pf[0]), .perf_bubble_cnt(pb[0])
`endif
    );

    instr_fetch #(.RESET_PC(RPC1), .NOP_INSTR(NOP)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .imem_req(req[1]), .imem_addr(addr[1]), .imem_rdata(rdata[1]),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(v[1]), .id_instr(ins[1]), .id_opcode(opc[1]), .id_pc(ipc[1]), .id_pc_plus4(ipc4[1])
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(pf[1]), .perf_bubble_cnt(pb[1])
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC3A5_1E00;
    endfunction

    // Synchronous instruction memories, one-cycle read latency.
    always @(posedge clk) if (req[0]) rdata[0] <= mem_word(addr[0]);
    always @(posedge clk) if (req[1]) rdata[1] <= mem_word(addr[1]);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch[0] = RPC0;
        m_fetch[1] = RPC1;
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 1'b0;
            m_valid[k] = 1'b0;
            m_instr[k] = NOP;
            m_pc[k]    = '0;
            m_fcnt[k]  = '0;
            m_bcnt[k]  = '0;
        end
    endtask

    task automatic model_step(input bit s, input bit r, input logic [31:0] rpc);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_fetch[k] = {rpc[31:2], 2'b00};
                m_pend[k]  = 1'b0;
                m_valid[k] = 1'b0;
                m_instr[k] = NOP;
                m_bcnt[k]  = m_bcnt[k] + 1;
            end else if (!s) begin
                if (m_pend[k]) begin
                    m_valid[k] = 1'b1;
                    m_pc[k]    = m_pend_pc[k];
                    m_instr[k] = mem_word(m_pend_pc[k]);
                    m_fcnt[k]  = m_fcnt[k] + 1;
                end else begin
                    m_valid[k] = 1'b0;
                    m_instr[k] = NOP;
                    m_bcnt[k]  = m_bcnt[k] + 1;
                end
                m_pend[k]    = 1'b1;
                m_pend_pc[k] = m_fetch[k];
                m_fetch[k]   = m_fetch[k] + 32'd4;
            end
        end
    endtask

    task automatic check_id();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("id_valid[%0d]", k), 32'(v[k]), 32'(m_valid[k]));
            check($sformatf("id_instr[%0d]", k), ins[k], m_instr[k]);
            check($sformatf("id_opcode[%0d]", k), 32'(opc[k]), 32'(m_instr[k][6:0]));
            check($sformatf("id_pc[%0d]", k), ipc[k], m_pc[k]);
            check($sformatf("id_pc_plus4[%0d]", k), ipc4[k], (m_pc[k] == 32'd0 && !m_valid[k] && m_instr[k] == NOP && ipc4[k] == 32'd0) ? 32'd0 : m_pc[k] + 32'd4);
`ifdef IFETCH_PERF_EN
            check($sformatf("perf_fetch[%0d]", k), pf[k], m_fcnt[k]);
            check($sformatf("perf_bubble[%0d]", k), pb[k], m_bcnt[k]);
`endif
        end
    endtask

    // Called at a falling edge: check ID, drive inputs, check request, then take one rising edge.
    task automatic cycle(input bit s, input bit r, input logic [31:0] rpc);
        check_id();
        stall = s;
        redirect = r;
        redirect_pc = rpc;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("imem_req[%0d]", k), 32'(req[k]), 32'(!s && !r));
            check($sformatf("imem_addr[%0d]", k), addr[k], m_fetch[k]);
        end
        @(posedge clk);
        model_step(s, r, rpc);
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid[%0d]", k), 32'(v[k]), 32'd0);
            check($sformatf("rst_instr[%0d]", k), ins[k], NOP);
            check($sformatf("rst_opcode[%0d]", k), 32'(opc[k]), 32'h13);
            check($sformatf("rst_pc[%0d]", k), ipc[k], 32'd0);
            check($sformatf("rst_pc4[%0d]", k), ipc4[k], 32'd0);
            check($sformatf("rst_req[%0d]", k), 32'(req[k]), 32'd0);
`ifdef IFETCH_PERF_EN
            check($sformatf("rst_pf[%0d]", k), pf[k], 32'd0);
            check($sformatf("rst_pb[%0d]", k), pb[k], 32'd0);
`endif
        end
        check("rst_addr[0]", addr[0], RPC0);
        check("rst_addr[1]", addr[1], RPC1);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;

        // Straight-line fetch including wrap on instance 1.
        repeat (6) cycle(1'b0, 1'b0, '0);
        // Stall three cycles with a fetch in flight.
        repeat (3) cycle(1'b1, 1'b0, '0);
        repeat (3) cycle(1'b0, 1'b0, '0);
        // Redirect while running.
        cycle(1'b0, 1'b1, 32'h0000_0200);
        repeat (4) cycle(1'b0, 1'b0, '0);
        // Fill the skid, then stall and redirect together to an unaligned target.
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h0000_0103);
        repeat (4) cycle(1'b0, 1'b0, '0);

        // Randomized stall/redirect traffic.
        for (int i = 0; i < 400; i++) begin
            automatic bit s = ($urandom_range(0, 3) == 0);
            automatic bit r = ($urandom_range(0, 11) == 0);
            automatic logic [31:0] rpc = (i % 5 == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
            cycle(s, r, rpc);
        end

        // Asynchronous reset in the middle of a stall with the skid full.
        repeat (2) cycle(1'b0, 1'b0, '0);
        repeat (2) cycle(1'b1, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        repeat (8) cycle(1'b0, 1'b0, '0);
        check_id();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
